// File: rtl/rgb_hue_fader.sv
// rgb_hue_fader: colour-wheel driver for a common RGB LED.
// A tick divider advances an N-bit ramp; every ramp overflow moves the wheel
// to the next of six sectors. Channel duties are derived from the sector and
// ramp (either a smooth cross-fade or six solid colours) and are turned into
// pin levels by a free-running PWM counter. Every output comes from a flop.
module rgb_hue_fader #(
   parameter int PWM_BITS    = 8,
   parameter int STEP_CYCLES = 7812,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       mode,
   input  logic       dir,
   output logic       RGB_R,
   output logic       RGB_G,
   output logic       RGB_B,
   output logic [2:0] sector,
   output logic       wrap
);

   localparam int TICK_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(STEP_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] MAX       = '1;
   localparam logic [PWM_BITS-1:0] ZERO      = '0;
   localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);

   // Pin level that means "LED channel dark".
   localparam logic OFF_LVL = (ACTIVE_LOW != 0);

   // Sector codes along the wheel.
   localparam logic [2:0] SEC_RED     = 3'd0;
   localparam logic [2:0] SEC_YELLOW  = 3'd1;
   localparam logic [2:0] SEC_GREEN   = 3'd2;
   localparam logic [2:0] SEC_CYAN    = 3'd3;
   localparam logic [2:0] SEC_BLUE    = 3'd4;
   localparam logic [2:0] SEC_MAGENTA = 3'd5;

   // Fade duties packed as {R, G, B}. Each sector raises or lowers exactly one
   // channel so the hue is continuous at every boundary, including 5 -> 0.
   // Sectors 6 and 7 cannot be reached; they yield a dark LED.
   function automatic logic [3*PWM_BITS-1:0] fade_duty(
      input logic [2:0]          sec,
      input logic [PWM_BITS-1:0] r
   );
      logic [PWM_BITS-1:0] inv;
      inv = MAX - r;
      case (sec)
         SEC_RED:     fade_duty = {MAX,  r,    ZERO};
         SEC_YELLOW:  fade_duty = {inv,  MAX,  ZERO};
         SEC_GREEN:   fade_duty = {ZERO, MAX,  r   };
         SEC_CYAN:    fade_duty = {ZERO, inv,  MAX };
         SEC_BLUE:    fade_duty = {r,    ZERO, MAX };
         SEC_MAGENTA: fade_duty = {MAX,  ZERO, inv };
         default:     fade_duty = {ZERO, ZERO, ZERO};
      endcase
   endfunction

   // Step mode keeps only channels that are fully lit at the sector start.
   function automatic logic [PWM_BITS-1:0] to_solid(input logic [PWM_BITS-1:0] d);
      to_solid = (d == MAX) ? MAX : ZERO;
   endfunction

   // MAX is forced to 100 % on; otherwise the channel is on while cnt < duty.
   function automatic logic pwm_on(
      input logic [PWM_BITS-1:0] duty,
      input logic [PWM_BITS-1:0] cnt
   );
      pwm_on = (duty == MAX) || (cnt < duty);
   endfunction

   logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic                  tick;
   logic [PWM_BITS-1:0]   ramp_q, ramp_d;
   logic [2:0]            sector_q, sector_d;
   logic                  wrap_q, wrap_d;
   logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic [2:0]            pins_q, pins_d;

   logic [3*PWM_BITS-1:0] fade_now;
   logic [3*PWM_BITS-1:0] fade_start;
   logic [PWM_BITS-1:0]   duty_r, duty_g, duty_b;

   // Tick divider: runs only while enabled, one tick per STEP_CYCLES clocks.
   always_comb begin
      tick       = 1'b0;
      tick_cnt_d = tick_cnt_q;
      if (en) begin
         if (tick_cnt_q == TICK_LAST) begin
            tick       = 1'b1;
            tick_cnt_d = '0;
         end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
         end
      end
   end

   // Wheel position: ramp within a sector, sector carry/borrow, wrap flag.
   always_comb begin
      ramp_d   = ramp_q;
      sector_d = sector_q;
      wrap_d   = 1'b0;
      if (tick) begin
         if (sector_q > SEC_MAGENTA) begin
            // Recover from a corrupted sector register.
            ramp_d   = ZERO;
            sector_d = SEC_RED;
         end else if (!dir) begin
            if (ramp_q == MAX) begin
               ramp_d = ZERO;
               if (sector_q == SEC_MAGENTA) begin
                  sector_d = SEC_RED;
                  wrap_d   = 1'b1;
               end else begin
                  sector_d = sector_q + 3'd1;
               end
            end else begin
               ramp_d = ramp_q + ONE;
            end
         end else begin
            if (ramp_q == ZERO) begin
               ramp_d = MAX;
               if (sector_q == SEC_RED) begin
                  sector_d = SEC_MAGENTA;
                  wrap_d   = 1'b1;
               end else begin
                  sector_d = sector_q - 3'd1;
               end
            end else begin
               ramp_d = ramp_q - ONE;
            end
         end
      end
   end

   // Channel duties for the current wheel position and output mode.
   always_comb begin
      fade_now   = fade_duty(sector_q, ramp_q);
      fade_start = fade_duty(sector_q, ZERO);
      if (mode) begin
         duty_r = fade_now[3*PWM_BITS-1:2*PWM_BITS];
         duty_g = fade_now[2*PWM_BITS-1:PWM_BITS];
         duty_b = fade_now[PWM_BITS-1:0];
      end else begin
         duty_r = to_solid(fade_start[3*PWM_BITS-1:2*PWM_BITS]);
         duty_g = to_solid(fade_start[2*PWM_BITS-1:PWM_BITS]);
         duty_b = to_solid(fade_start[PWM_BITS-1:0]);
      end
   end

   // PWM compare and pin polarity; the counter free-runs regardless of en.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + ONE;
      pins_d    = {pwm_on(duty_r, pwm_cnt_q),
                   pwm_on(duty_g, pwm_cnt_q),
                   pwm_on(duty_b, pwm_cnt_q)} ^ {3{OFF_LVL}};
   end

   // State registers; reset parks the wheel at red with all pins dark.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= '0;
         ramp_q     <= ZERO;
         sector_q   <= SEC_RED;
         wrap_q     <= 1'b0;
         pwm_cnt_q  <= ZERO;
         pins_q     <= {3{OFF_LVL}};
      end else begin
         tick_cnt_q <= tick_cnt_d;
         ramp_q     <= ramp_d;
         sector_q   <= sector_d;
         wrap_q     <= wrap_d;
         pwm_cnt_q  <= pwm_cnt_d;
         pins_q     <= pins_d;
      end
   end

   assign RGB_R  = pins_q[2];
   assign RGB_G  = pins_q[1];
   assign RGB_B  = pins_q[0];
   assign sector = sector_q;
   assign wrap   = wrap_q;

endmodule

// File: tb/tb_rgb_hue_fader.sv
// Directed bench for rgb_hue_fader: a small instance (2-bit PWM, 3-clock
// tick, active-low pins) for the wheel behaviour and a wide one (8-bit PWM,
// tick every clock, active-high pins) for polarity and full-wheel timing.
module tb_rgb_hue_fader;

   logic       clk = 1'b0;
   logic       rst, en, mode, dir;
   logic       r1, g1, b1, wrap1;
   logic [2:0] sec1;
   logic       rst2, en2, mode2, dir2;
   logic       r2, g2, b2, wrap2;
   logic [2:0] sec2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rgb_hue_fader #(.PWM_BITS(2), .STEP_CYCLES(3), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
      .RGB_R(r1), .RGB_G(g1), .RGB_B(b1), .sector(sec1), .wrap(wrap1)
   );

   rgb_hue_fader #(.PWM_BITS(8), .STEP_CYCLES(1), .ACTIVE_LOW(0)) dut2 (
      .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .dir(dir2),
      .RGB_R(r2), .RGB_G(g2), .RGB_B(b2), .sector(sec2), .wrap(wrap2)
   );

   // Advance n rising edges, ending on a falling edge.
   task automatic edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reset the small instance and release it with the given controls.
   task automatic restart(input logic e, input logic m, input logic d);
      rst = 1'b1;
      en = e; mode = m; dir = d;
      edges(2);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      edges(1);
      checks++;
      if (sec1 !== 3'd0 || wrap1 !== 1'b0 || {r1, g1, b1} !== 3'b111) begin
         errors++;
         $display("FAIL reset_init: sector=%0d wrap=%0b pins=%b, expected 0 0 111", sec1, wrap1, {r1, g1, b1});
      end
      checks++;
      if (sec2 !== 3'd0 || wrap2 !== 1'b0 || {r2, g2, b2} !== 3'b000) begin
         errors++;
         $display("FAIL reset_init_hi: sector=%0d wrap=%0b pins=%b, expected 0 0 000", sec2, wrap2, {r2, g2, b2});
      end
      // Run to sector 3 mid-sector, then hit reset asynchronously.
      rst = 1'b0; en = 1'b1; mode = 1'b1; dir = 1'b0;
      edges(40);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (sec1 !== 3'd0 || wrap1 !== 1'b0 || {r1, g1, b1} !== 3'b111) begin
         errors++;
         $display("FAIL reset_async: sector=%0d wrap=%0b pins=%b, expected 0 0 111", sec1, wrap1, {r1, g1, b1});
      end
      edges(2);
      rst = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         edges(1);
         checks++;
         if (r1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_red_on: edge %0d R=%0b expected 0", n, r1);
         end
         if (n <= 4) begin
            checks++;
            if (g1 !== 1'b1 || b1 !== 1'b1) begin
               errors++;
               $display("FAIL reset_gb_off: edge %0d G=%0b B=%0b expected 1 1", n, g1, b1);
            end
         end
      end
   endtask

   task automatic test_forward_fade;
      restart(1'b1, 1'b1, 1'b0);
      for (int n = 1; n <= 80; n++) begin
         edges(1);
         checks++;
         if (sec1 !== 3'((n / 12) % 6)) begin
            errors++;
            $display("FAIL fwd_sector: edge %0d sector=%0d expected %0d", n, sec1, (n / 12) % 6);
         end
         checks++;
         if (wrap1 !== (n == 72)) begin
            errors++;
            $display("FAIL fwd_wrap: edge %0d wrap=%0b expected %0b", n, wrap1, (n == 72));
         end
      end
   endtask

   // Freeze the wheel at each ramp value of sector 0 and measure G on-time.
   task automatic test_fade_duty;
      int g_on, r_on;
      restart(1'b0, 1'b1, 1'b0);
      for (int r = 0; r < 4; r++) begin
         if (r > 0) begin
            en = 1'b1;
            edges(3);
            en = 1'b0;
         end
         g_on = 0; r_on = 0;
         for (int k = 0; k < 4; k++) begin
            edges(1);
            if (g1 == 1'b0) g_on++;
            if (r1 == 1'b0) r_on++;
         end
         checks++;
         if (g_on != ((r == 3) ? 4 : r)) begin
            errors++;
            $display("FAIL fade_g_duty: ramp %0d on=%0d expected %0d", r, g_on, (r == 3) ? 4 : r);
         end
         checks++;
         if (r_on != 4) begin
            errors++;
            $display("FAIL fade_r_duty: ramp %0d on=%0d expected 4", r, r_on);
         end
      end
   endtask

   task automatic test_step_mode;
      logic [2:0] colour [6];
      colour = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
      restart(1'b1, 1'b0, 1'b0);
      for (int n = 1; n <= 84; n++) begin
         edges(1);
         checks++;
         if ({r1, g1, b1} !== colour[((n - 1) / 12) % 6]) begin
            errors++;
            $display("FAIL step_colour: edge %0d pins=%b expected %b", n, {r1, g1, b1}, colour[((n - 1) / 12) % 6]);
         end
      end
   endtask

   task automatic test_reverse_wrap;
      int b_on;
      int exp_on [3];
      exp_on = '{2, 1, 0};
      restart(1'b1, 1'b1, 1'b1);
      for (int n = 1; n <= 9; n++) begin
         edges(1);
         checks++;
         if (wrap1 !== (n == 3) || sec1 !== ((n < 3) ? 3'd0 : 3'd5)) begin
            errors++;
            $display("FAIL rev_first: edge %0d sector=%0d wrap=%0b", n, sec1, wrap1);
         end
         if (n >= 4 && n <= 6) begin
            checks++;
            if ({r1, g1, b1} !== 3'b011) begin
               errors++;
               $display("FAIL rev_red: edge %0d pins=%b expected 011", n, {r1, g1, b1});
            end
         end
      end
      // Ramp now 1 in sector 5; measure, reverse direction, climb back up.
      for (int s = 0; s < 3; s++) begin
         if (s > 0) begin
            dir = 1'b0;
            en  = 1'b1;
            edges(3);
         end
         en = 1'b0;
         b_on = 0;
         for (int k = 0; k < 4; k++) begin
            edges(1);
            if (b1 == 1'b0) b_on++;
         end
         checks++;
         if (b_on != exp_on[s] || sec1 !== 3'd5) begin
            errors++;
            $display("FAIL rev_dir_change: step %0d B on=%0d sector=%0d expected %0d 5", s, b_on, sec1, exp_on[s]);
         end
      end
      en = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         edges(1);
         checks++;
         if (wrap1 !== (n == 3)) begin
            errors++;
            $display("FAIL fwd_wrap_back: edge %0d wrap=%0b expected %0b", n, wrap1, (n == 3));
         end
      end
      checks++;
      if (sec1 !== 3'd0) begin
         errors++;
         $display("FAIL fwd_wrap_sector: sector=%0d expected 0", sec1);
      end
   endtask

   task automatic test_pause;
      int b_on;
      restart(1'b1, 1'b1, 1'b0);
      edges(28);
      en = 1'b0;
      b_on = 0;
      for (int n = 0; n < 50; n++) begin
         edges(1);
         if (b1 == 1'b0) b_on++;
         checks++;
         if (sec1 !== 3'd2 || r1 !== 1'b1 || g1 !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold: cycle %0d sector=%0d R=%0b G=%0b expected 2 1 0", n, sec1, r1, g1);
         end
      end
      checks++;
      if (b_on != 13) begin
         errors++;
         $display("FAIL pause_pwm: B on=%0d expected 13", b_on);
      end
      // Held tick count is 1: one enabled clock must not tick, the next must.
      for (int s = 1; s <= 2; s++) begin
         en = 1'b1;
         edges(1);
         en = 1'b0;
         b_on = 0;
         for (int k = 0; k < 4; k++) begin
            edges(1);
            if (b1 == 1'b0) b_on++;
         end
         checks++;
         if (b_on != s) begin
            errors++;
            $display("FAIL pause_resume: step %0d B on=%0d expected %0d", s, b_on, s);
         end
      end
   endtask

   task automatic test_polarity_extremes;
      en2 = 1'b1; mode2 = 1'b1; dir2 = 1'b0;
      rst2 = 1'b0;
      for (int n = 1; n <= 3080; n++) begin
         edges(1);
         if (n <= 256) begin
            checks++;
            if (r2 !== 1'b1 || b2 !== 1'b0 || g2 !== (n == 256)) begin
               errors++;
               $display("FAIL pol_levels: edge %0d R=%0b G=%0b B=%0b expected 1 %0b 0", n, r2, g2, b2, (n == 256));
            end
         end
         if (n == 256) begin
            checks++;
            if (sec2 !== 3'd1) begin
               errors++;
               $display("FAIL pol_sector: sector=%0d expected 1", sec2);
            end
         end
         checks++;
         if (wrap2 !== (n == 1536 || n == 3072)) begin
            errors++;
            $display("FAIL pol_wrap: edge %0d wrap=%0b expected %0b", n, wrap2, (n == 1536 || n == 3072));
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b1; dir = 1'b0;
      rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b1; dir2 = 1'b0;
      test_reset;
      test_forward_fade;
      test_fade_duty;
      test_step_mode;
      test_reverse_wrap;
      test_pause;
      test_polarity_extremes;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
